// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the in-order integer pipeline.
// Tracks in-flight instructions in a shift-register scoreboard from EX (slot 0) to the last write-back slot.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned FWD_STAGES = 2,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned SW        = $clog2(FWD_STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              ex_branch_taken,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              flush_if_id,
   output logic [SW-1:0]     ex_fwd_a,
   output logic [SW-1:0]     ex_fwd_b,
   output logic [FWD_STAGES:0] slot_valid,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [FWD_STAGES:0] r_valid;
   logic [FWD_STAGES:0] r_rw;
   logic [FWD_STAGES:0] r_mr;
   logic [REG_AW-1:0]   r_rd [FWD_STAGES+1];
   logic [REG_AW-1:0]   r_rs;
   logic [REG_AW-1:0]   r_rt;
   logic                r_use_rs;
   logic                r_use_rt;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_ld_hit;
   logic                w_flush;
   logic                w_stall;
   logic                w_bubble;
   logic [SW-1:0]       w_fwd_a;
   logic [SW-1:0]       w_fwd_b;

   // A load is only a hazard while it sits in a slot that cannot yet forward its data.
   always_comb begin
      w_ld_hit = 1'b0;
      for (int unsigned j = 0; j < LOAD_LAT; j++) begin
         if (r_valid[j] && r_mr[j] && r_rw[j] && (r_rd[j] != '0) &&
             ((id_use_rs && (r_rd[j] == id_rs)) || (id_use_rt && (r_rd[j] == id_rt))))
            w_ld_hit = 1'b1;
      end
      w_flush  = ex_branch_taken & r_valid[0];
      w_stall  = id_valid & w_ld_hit & ~w_flush;
      w_bubble = ~id_valid | w_stall | w_flush;
   end

   // Scan oldest to youngest so the youngest producer overwrites the selection.
   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
         if (r_valid[k] && r_rw[k] && (r_rd[k] != '0)) begin
            if (r_rd[k] == r_rs) w_fwd_a = SW'(k);
            if (r_rd[k] == r_rt) w_fwd_b = SW'(k);
         end
      end
      if (!r_valid[0] || !r_use_rs) w_fwd_a = '0;
      if (!r_valid[0] || !r_use_rt) w_fwd_b = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_rw        <= '0;
         r_mr        <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_use_rs    <= 1'b0;
         r_use_rt    <= 1'b0;
         r_stall_cnt <= '0;
         for (int unsigned i = 0; i <= FWD_STAGES; i++) r_rd[i] <= '0;
      end else if (!hold) begin
         for (int unsigned i = FWD_STAGES; i >= 1; i--) begin
            r_valid[i] <= r_valid[i-1];
            r_rw[i]    <= r_rw[i-1];
            r_mr[i]    <= r_mr[i-1];
            r_rd[i]    <= r_rd[i-1];
         end
         if (w_bubble) begin
            r_valid[0] <= 1'b0;
            r_rw[0]    <= 1'b0;
            r_mr[0]    <= 1'b0;
            r_rd[0]    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_use_rs   <= 1'b0;
            r_use_rt   <= 1'b0;
         end else begin
            r_valid[0] <= 1'b1;
            r_rw[0]    <= id_reg_write;
            r_mr[0]    <= id_mem_read;
            r_rd[0]    <= id_rd;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_use_rs   <= id_use_rs;
            r_use_rt   <= id_use_rt;
         end
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign pc_write    = ~hold & ~w_stall;
   assign if_id_write = ~hold & ~w_stall;
   assign flush_if_id = ~hold & w_flush;
   assign ex_fwd_a    = w_fwd_a;
   assign ex_fwd_b    = w_fwd_b;
   assign slot_valid  = r_valid;
   assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance (u0) and a LOAD_LAT=2, FWD_STAGES=3 instance (u1).
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hold = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
   logic       ex_branch_taken = 1'b0;

   logic        pc_write0, if_id_write0, flush0;
   logic [1:0]  fwd_a0, fwd_b0;
   logic [2:0]  slot_valid0;
   logic [15:0] stall_cnt0;

   logic        pc_write1, if_id_write1, flush1;
   logic [1:0]  fwd_a1, fwd_b1;
   logic [3:0]  slot_valid1;
   logic [15:0] stall_cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write0), .if_id_write(if_id_write0),
      .flush_if_id(flush0), .ex_fwd_a(fwd_a0), .ex_fwd_b(fwd_b0),
      .slot_valid(slot_valid0), .stall_cnt(stall_cnt0)
   );

   pipe_hazard_ctrl #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write1), .if_id_write(if_id_write1),
      .flush_if_id(flush1), .ex_fwd_a(fwd_a1), .ex_fwd_b(fwd_b1),
      .slot_valid(slot_valid1), .stall_cnt(stall_cnt1)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic nop;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset;
      hold = 1'b0; ex_branch_taken = 1'b0; nop();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      n_tests++; if (slot_valid0 !== 3'b000) begin n_fail++; $display("FAIL reset_slot_valid: got %b expected 000", slot_valid0); end
      n_tests++; if (stall_cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt0); end
      n_tests++; if (pc_write0 !== 1'b1 || if_id_write0 !== 1'b1) begin n_fail++; $display("FAIL reset_write_en: got pc=%b ifid=%b expected 1 1", pc_write0, if_id_write0); end
      n_tests++; if (flush0 !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush0); end
      n_tests++; if (fwd_a0 !== 2'd0 || fwd_b0 !== 2'd0) begin n_fail++; $display("FAIL reset_fwd: got a=%0d b=%0d expected 0 0", fwd_a0, fwd_b0); end
      n_tests++; if (slot_valid1 !== 4'b0000) begin n_fail++; $display("FAIL reset_slot_valid_u1: got %b expected 0000", slot_valid1); end
   endtask

   task automatic test_alu_fwd;
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3 <- r1,r2
      step();
      set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // sub r5 <- r3,r4
      #1;
      n_tests++; if (pc_write0 !== 1'b1) begin n_fail++; $display("FAIL alu_no_stall: got pc_write=%b expected 1", pc_write0); end
      n_tests++; if (fwd_a0 !== 2'd0) begin n_fail++; $display("FAIL alu_fwd_none: got %0d expected 0", fwd_a0); end
      step();
      set_id(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // or r6 <- r3,r7
      #1;
      n_tests++; if (fwd_a0 !== 2'd1) begin n_fail++; $display("FAIL alu_fwd_a_slot1: got %0d expected 1", fwd_a0); end
      n_tests++; if (fwd_b0 !== 2'd0) begin n_fail++; $display("FAIL alu_fwd_b_none: got %0d expected 0", fwd_b0); end
      step();
      nop();
      #1;
      n_tests++; if (fwd_a0 !== 2'd2) begin n_fail++; $display("FAIL alu_fwd_a_slot2: got %0d expected 2", fwd_a0); end
      n_tests++; if (slot_valid0 !== 3'b111) begin n_fail++; $display("FAIL alu_slot_valid: got %b expected 111", slot_valid0); end
      n_tests++; if (stall_cnt0 !== 16'd0) begin n_fail++; $display("FAIL alu_stall_cnt: got %0d expected 0", stall_cnt0); end
   endtask

   task automatic test_load_use;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw r8
      step();
      set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add r9 <- r8,r8
      #1;
      n_tests++; if (pc_write0 !== 1'b0 || if_id_write0 !== 1'b0) begin n_fail++; $display("FAIL lu_stall: got pc=%b ifid=%b expected 0 0", pc_write0, if_id_write0); end
      step();
      #1;
      n_tests++; if (pc_write0 !== 1'b1) begin n_fail++; $display("FAIL lu_release: got pc_write=%b expected 1", pc_write0); end
      n_tests++; if (slot_valid0 !== 3'b010) begin n_fail++; $display("FAIL lu_bubble: got %b expected 010", slot_valid0); end
      n_tests++; if (stall_cnt0 !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt0); end
      step();
      nop();
      #1;
      n_tests++; if (slot_valid0 !== 3'b101) begin n_fail++; $display("FAIL lu_slot_valid: got %b expected 101", slot_valid0); end
      n_tests++; if (fwd_a0 !== 2'd2 || fwd_b0 !== 2'd2) begin n_fail++; $display("FAIL lu_fwd: got a=%0d b=%0d expected 2 2", fwd_a0, fwd_b0); end
      n_tests++; if (stall_cnt0 !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt_hold: got %0d expected 1", stall_cnt0); end
   endtask

   task automatic test_load_lat2;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      #1;
      n_tests++; if (pc_write1 !== 1'b0) begin n_fail++; $display("FAIL ll2_stall1: got pc_write=%b expected 0", pc_write1); end
      step();
      #1;
      n_tests++; if (pc_write1 !== 1'b0) begin n_fail++; $display("FAIL ll2_stall2: got pc_write=%b expected 0", pc_write1); end
      step();
      #1;
      n_tests++; if (pc_write1 !== 1'b1) begin n_fail++; $display("FAIL ll2_release: got pc_write=%b expected 1", pc_write1); end
      step();
      nop();
      #1;
      n_tests++; if (fwd_a1 !== 2'd3 || fwd_b1 !== 2'd3) begin n_fail++; $display("FAIL ll2_fwd: got a=%0d b=%0d expected 3 3", fwd_a1, fwd_b1); end
      n_tests++; if (slot_valid1 !== 4'b1001) begin n_fail++; $display("FAIL ll2_slot_valid: got %b expected 1001", slot_valid1); end
      n_tests++; if (stall_cnt1 !== 16'd2) begin n_fail++; $display("FAIL ll2_stall_cnt: got %0d expected 2", stall_cnt1); end
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw r0
      step();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add r9 <- r0,r0
      #1;
      n_tests++; if (pc_write1 !== 1'b1) begin n_fail++; $display("FAIL r0_no_stall: got pc_write=%b expected 1", pc_write1); end
      step();
      nop();
      #1;
      n_tests++; if (fwd_a1 !== 2'd0 || fwd_b1 !== 2'd0) begin n_fail++; $display("FAIL r0_no_fwd: got a=%0d b=%0d expected 0 0", fwd_a1, fwd_b1); end
      n_tests++; if (stall_cnt1 !== 16'd0) begin n_fail++; $display("FAIL r0_stall_cnt: got %0d expected 0", stall_cnt1); end
   endtask

   task automatic test_flush;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw r8
      step();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);   // beq r1,r2
      step();
      set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add r9 <- r8,r8 (load-use in u1)
      ex_branch_taken = 1'b1;
      #1;
      n_tests++; if (flush1 !== 1'b1) begin n_fail++; $display("FAIL flush_u1: got %b expected 1", flush1); end
      n_tests++; if (pc_write1 !== 1'b1 || if_id_write1 !== 1'b1) begin n_fail++; $display("FAIL flush_beats_stall: got pc=%b ifid=%b expected 1 1", pc_write1, if_id_write1); end
      n_tests++; if (flush0 !== 1'b1) begin n_fail++; $display("FAIL flush_u0: got %b expected 1", flush0); end
      step();
      nop();
      #1;
      n_tests++; if (slot_valid1 !== 4'b0110) begin n_fail++; $display("FAIL flush_bubble: got %b expected 0110", slot_valid1); end
      n_tests++; if (stall_cnt1 !== 16'd0) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d expected 0", stall_cnt1); end
      n_tests++; if (flush0 !== 1'b0) begin n_fail++; $display("FAIL flush_ignored_invalid: got %b expected 0", flush0); end
      ex_branch_taken = 1'b0;
   endtask

   task automatic test_double_producer;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd4, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      step();
      nop();
      #1;
      n_tests++; if (fwd_a0 !== 2'd1) begin n_fail++; $display("FAIL dp_youngest: got %0d expected 1", fwd_a0); end
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);   // same rd, no write
      step();
      set_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd4, 5'd4, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);   // rs not actually read
      #1;
      n_tests++; if (fwd_a0 !== 2'd2 || fwd_b0 !== 2'd2) begin n_fail++; $display("FAIL dp_no_write: got a=%0d b=%0d expected 2 2", fwd_a0, fwd_b0); end
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd4, 5'd4, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
      step();
      nop();
      #1;
      n_tests++; if (fwd_a0 !== 2'd0 || fwd_b0 !== 2'd1) begin n_fail++; $display("FAIL dp_use_rs: got a=%0d b=%0d expected 0 1", fwd_a0, fwd_b0); end
   endtask

   task automatic test_hold_reset;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw r8
      step();
      set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add r9 (stalls once)
      step();
      step();
      set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1);  // lw r10 <- [r9]
      step();
      set_id(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
      hold = 1'b1;
      ex_branch_taken = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (pc_write0 !== 1'b0 || if_id_write0 !== 1'b0 || flush0 !== 1'b0) begin n_fail++; $display("FAIL hold_ctrl[%0d]: got pc=%b ifid=%b flush=%b expected 0 0 0", i, pc_write0, if_id_write0, flush0); end
         n_tests++; if (slot_valid0 !== 3'b011 || stall_cnt0 !== 16'd1) begin n_fail++; $display("FAIL hold_frozen[%0d]: got slots=%b cnt=%0d expected 011 1", i, slot_valid0, stall_cnt0); end
         n_tests++; if (fwd_a0 !== 2'd1) begin n_fail++; $display("FAIL hold_fwd[%0d]: got %0d expected 1", i, fwd_a0); end
         step();
      end
      hold = 1'b0;
      ex_branch_taken = 1'b0;
      #1;
      n_tests++; if (pc_write0 !== 1'b0) begin n_fail++; $display("FAIL hold_release_stall: got pc_write=%b expected 0", pc_write0); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (slot_valid0 !== 3'b000 || stall_cnt0 !== 16'd0) begin n_fail++; $display("FAIL midstall_reset: got slots=%b cnt=%0d expected 000 0", slot_valid0, stall_cnt0); end
      n_tests++; if (pc_write0 !== 1'b1 || fwd_a0 !== 2'd0) begin n_fail++; $display("FAIL midstall_reset_out: got pc=%b fwd_a=%0d expected 1 0", pc_write0, fwd_a0); end
      step();
      rst_n = 1'b1;
      nop();
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_load_lat2();
      test_flush();
      test_double_producer();
      test_hold_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall/flush controller for the in-order integer pipeline. It replaces the separate fixed two-stage hazard detection and forwarding units with one block. The block keeps its own shift-register scoreboard of in-flight instructions, from the ID/EX slot through the last write-back slot. It generalises to any forwarding depth, any register-address width and any multi-cycle load latency, and adds branch flush, global hold and a stall counter.

Parameters:
REG_AW, 5, register-address width.
FWD_STAGES, 2, number of forwarding sources after EX (slot 1 = EX/MEM, slot 2 = MEM/WB, ...); must be >= LOAD_LAT+1.
LOAD_LAT, 1, number of slots after EX before load data can be forwarded; load data is forwardable from slot LOAD_LAT+1 onward.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
hold  in  1  global freeze; all slots and the counter hold their values.
id_valid  in  1  ID stage holds a real instruction.
id_rs, id_rt  in  REG_AW  source register numbers of the ID instruction.
id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs/rt.
id_rd  in  REG_AW  final destination register (rd/rt mux already resolved).
id_reg_write, id_mem_read  in  1  control bits of the ID instruction.
ex_branch_taken  in  1  the branch in slot 0 (EX) has resolved as taken.
pc_write, if_id_write  out  1  PC and IF/ID register enables.
flush_if_id  out  1  clear IF/ID to a NOP.
ex_fwd_a, ex_fwd_b  out  SW=clog2(FWD_STAGES+1)  EX operand source: 0 = ID/EX register value, k = slot k result.
slot_valid  out  FWD_STAGES+1  valid bit of each slot; bit 0 = EX.
stall_cnt  out  CNT_W  count of load-use stall cycles, saturating.

Behaviour:
- Slot state: each slot i (0..FWD_STAGES) holds valid, rd, reg_write, mem_read. Slot 0 also holds rs, rt, use_rs and use_rt.
- Reset (async, rst_n=0): every slot valid=0 and every field 0; stall_cnt=0. The outputs follow combinationally: pc_write=1, if_id_write=1, flush_if_id=0, ex_fwd_a/b=0.
- Advance: at each rising edge with hold=0, slot i+1 takes slot i and the oldest slot drops out. Slot 0 loads the ID instruction, or a bubble (valid=0) when the ID instruction is stalled or flushed.
- Load-use stall (combinational):
  - stall=1 when id_valid and some slot j < LOAD_LAT has valid, mem_read, reg_write and rd!=0, and rd equals id_rs (with id_use_rs=1) or id_rt (with id_use_rt=1).
  - While stalled: pc_write=0, if_id_write=0, and a bubble enters slot 0.
  - A stall longer than one cycle (LOAD_LAT>1) re-evaluates each cycle as the load moves through the slots.
- Flush: ex_branch_taken=1 and slot0.valid=1 gives flush_if_id=1, a bubble into slot 0, pc_write=1 and if_id_write=1.
  - Flush has priority over stall: stall is suppressed and stall_cnt is not incremented.
  - ex_branch_taken with slot0.valid=0 is ignored.
- Forwarding (combinational, per operand, shown for A; B is identical with rt):
  - ex_fwd_a = smallest k in 1..FWD_STAGES with slot k valid, reg_write, rd!=0, rd==slot0.rs, and slot0.use_rs=1. Otherwise ex_fwd_a=0.
  - The youngest producer wins. Register 0 is never forwarded.
  - If slot 0 is invalid, ex_fwd_a=ex_fwd_b=0.
- hold=1:
  - Nothing in the block updates.
  - pc_write=0, if_id_write=0, flush_if_id=0.
  - ex_fwd outputs still reflect the current slot contents.
- stall_cnt: +1 on each edge with stall=1, hold=0 and no flush; it saturates at all-ones.
- Reset asserted mid-stall or mid-flush: state clears immediately and pending hazards are dropped.

Test Plan:
- Back-to-back ALU dependency, default parameters: slot0 = add r3←r1,r2, next is sub r5←r3,r4. One cycle later ex_fwd_a=1; the cycle after that, an unrelated consumer of r3 sees ex_fwd_a=2. stall_cnt stays 0.
- Load-use: lw r8 in slot 0 while ID holds add r9←r8,r8 (use_rs=use_rt=1). Expect one cycle of pc_write=0 and if_id_write=0, then slot_valid=3'b101. The next cycle gives ex_fwd_a=ex_fwd_b=2, and stall_cnt=1.
- LOAD_LAT=2, FWD_STAGES=3: the same lw/add pair stalls two cycles, then ex_fwd_a=3 and stall_cnt=2. A dependency on r0 never stalls or forwards.
- Branch flush with a simultaneous load-use hazard: ex_branch_taken=1, slot0 valid, and the ID instruction dependent on an older load. Expect flush_if_id=1, pc_write=1, slot 0 a bubble next cycle, and stall_cnt unchanged.
- Double producer: slot1.rd=r4 and slot2.rd=r4, consumer reads r4 → ex_fwd_a=1. Clearing slot1.reg_write → ex_fwd_a=2.
- hold held 3 cycles during a stall, then rst_n pulsed low: slots and stall_cnt are frozen during hold; after reset all slot_valid=0, stall_cnt=0 and pc_write=1.
